mc_controller: RTL and testbench

//  Control unit for the multicycle RV32I datapath: Moore FSM (main decoder) plus ALU and immediate decoders.

---
 rtl/mc_controller.sv | 181 ++++++++++++++++++
 tb/tb_mc_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Control unit for the multicycle RV32I datapath: Moore main-decoder FSM
// together with the ALU-control and immediate-select decoders.
module mc_controller #(
  parameter bit BNE_EN  = 1'b1,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_ALUWB, S_EXECI, S_JAL, S_BRANCH
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_upd;
  logic       branch;
  logic       dec_illegal;
  logic       taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Unsupported opcodes and funct3 encodings are caught once, in DECODE.
  always_comb begin
    dec_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_JAL: dec_illegal = 1'b0;
      OP_R, OP_I: dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b010 ||
                                  funct3 == 3'b110 || funct3 == 3'b111);
      OP_BR: dec_illegal = !(funct3 == 3'b000 || (BNE_EN && funct3 == 3'b001));
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    pc_upd     = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_upd     = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (dec_illegal) state_d = S_FETCH;
        else begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_JAL:       state_d = S_JAL;
            OP_BR:        state_d = S_BRANCH;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_upd    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign taken    = (funct3 == 3'b000 && zero) ||
                    (BNE_EN && funct3 == 3'b001 && !zero);
  assign pc_write = pc_upd | (branch & taken);
  assign illegal  = (state_q == S_DECODE) && dec_illegal;
  assign dbg_state = state_q;

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Subtract only for R-type with funct7[5] set; I-type funct3=000 is always addi.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed and random instructions checked cycle by
// cycle against a per-instruction state path and per-state output table.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] dbg_state;

  int checks = 0;
  int passes = 0;

  mc_controller #(.BNE_EN(1'b1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Per-state Moore outputs, index = state number.
  localparam logic       T_ADR [11] = '{0,0,0,1,0,1,0,0,0,0,0};
  localparam logic       T_MW  [11] = '{0,0,0,0,0,1,0,0,0,0,0};
  localparam logic       T_IRW [11] = '{1,0,0,0,0,0,0,0,0,0,0};
  localparam logic [1:0] T_RES [11] = '{2,0,0,0,1,0,0,0,0,0,0};
  localparam logic [1:0] T_A   [11] = '{0,1,2,0,0,0,2,0,2,1,2};
  localparam logic [1:0] T_B   [11] = '{2,1,1,0,0,0,0,0,1,2,0};
  localparam logic       T_RW  [11] = '{0,0,0,0,1,0,0,1,0,0,0};
  localparam logic       T_PCU [11] = '{1,0,0,0,0,0,0,0,0,1,0};
  localparam logic       T_BR  [11] = '{0,0,0,0,0,0,0,0,0,0,1};
  localparam logic [1:0] T_AOP [11] = '{0,0,0,0,0,0,2,0,2,0,1};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'b0000011, 7'b0100011, 7'b1101111: return 1'b1;
      7'b0110011, 7'b0010011: return (f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7);
      7'b1100011: return (f3 == 0 || f3 == 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic [1:0] aop, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
    if (aop == 1) return 3'b001;
    if (aop != 2) return 3'b000;
    case (f3)
      3'd0: return (o[5] && f7) ? 3'b001 : 3'b000;
      3'd2: return 3'b101;
      3'd6: return 3'b011;
      3'd7: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check_state(input int s);
    logic tk;
    tk = (funct3 == 0 && zero) || (funct3 == 1 && !zero);
    chk("dbg_state", 8'(dbg_state), 8'(s));
    chk("adr_src", 8'(adr_src), 8'(T_ADR[s]));
    chk("mem_write", 8'(mem_write), 8'(T_MW[s]));
    chk("ir_write", 8'(ir_write), 8'(T_IRW[s]));
    chk("result_src", 8'(result_src), 8'(T_RES[s]));
    chk("alu_src_a", 8'(alu_src_a), 8'(T_A[s]));
    chk("alu_src_b", 8'(alu_src_b), 8'(T_B[s]));
    chk("reg_write", 8'(reg_write), 8'(T_RW[s]));
    chk("pc_write", 8'(pc_write), 8'(T_PCU[s] | (T_BR[s] & tk)));
    chk("alu_control", 8'(alu_control), 8'(exp_alu(T_AOP[s], op, funct3, funct7b5)));
    chk("imm_src", 8'(imm_src), 8'(exp_imm(op)));
    chk("illegal", 8'(illegal), 8'((s == 1) && !legal(op, funct3)));
  endtask

  // Called #1 after an edge with the DUT in FETCH; returns the same way.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    int path[$];
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    path = '{0, 1};
    if (legal(o, f3)) begin
      case (o)
        7'b0000011: path = '{0, 1, 2, 3, 4};
        7'b0100011: path = '{0, 1, 2, 5};
        7'b0110011: path = '{0, 1, 6, 7};
        7'b0010011: path = '{0, 1, 8, 7};
        7'b1101111: path = '{0, 1, 9, 7};
        default:    path = '{0, 1, 10};
      endcase
    end
    #1;
    foreach (path[i]) begin
      check_state(path[i]);
      @(posedge clk); #1;
    end
    chk("back_to_fetch", 8'(dbg_state), 8'd0);
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] ro;
    logic [2:0] rf3;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    reset = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 8'(dbg_state), 8'd0);
    chk("rst_ir_write", 8'(ir_write), 8'd1);
    chk("rst_pc_write", 8'(pc_write), 8'd1);
    chk("rst_mem_write", 8'(mem_write), 8'd0);
    reset = 1'b0;
    #1;
    check_state(0);

    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);
    run_instr(7'b0110011, 3'd6, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b1);
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'd1, 1'b0, 1'b0);
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      ro  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      rf3 = 3'($urandom);
      if ((ro == 7'b0110011 || ro == 7'b0010011) && $urandom_range(0, 3) != 0)
        rf3 = (rf3[1:0] == 2'd1) ? 3'd2 : ((rf3[1:0] == 2'd3) ? 3'd7 : {rf3[1], rf3[1], 1'b0});
      if (ro == 7'b1100011 && $urandom_range(0, 3) != 0) rf3 = {2'b00, rf3[0]};
      run_instr(ro, rf3, 1'($urandom), 1'($urandom));
    end

    // Abort a store while it is strobing memory.
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sw_state5", 8'(dbg_state), 8'd5);
    chk("sw_mem_write", 8'(mem_write), 8'd1);
    reset = 1'b1;
    #1;
    chk("abort_mem_write", 8'(mem_write), 8'd0);
    chk("abort_state", 8'(dbg_state), 8'd0);
    chk("abort_ir_write", 8'(ir_write), 8'd1);
    @(posedge clk); #1;
    chk("abort_hold", 8'(dbg_state), 8'd0);
    reset = 1'b0;
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
